// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a small bank of 32-bit registers.
// Register 0 is a read-only ID word. Registers 1..NUM_REGS-1 are read/write
// with byte strobes. Each access phase holds pready low for WAIT_CYCLES
// cycles, and pready, pslverr and prdata are all registered.
// Optional feature: define APB_SLV_PROT_CHECK_EN to reject unprivileged
// accesses (pprot[0]=0) to the upper half of the register bank.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no transfer in flight; waiting for a setup phase
// S_WAIT | request latched; counting down access cycles with pready low
// S_RESP | pready high for one cycle; a clean write commits on exit

module apb_slave_regfile #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [31:0] i_paddr,
  input  logic [31:0] i_pwdata,
  input  logic [3:0]  i_pstrb,
  input  logic [2:0]  i_pprot,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_pslverr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_paddr;
  logic        r_pwrite;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;
  logic [2:0]  r_pprot;
  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;
  logic [31:0] r_regs [NUM_REGS];

  logic [31:0] w_addr;
  logic        w_write;
  logic [2:0]  w_prot;
  logic [29:0] w_idx;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_unused_prot;

  // When WAIT_CYCLES is 0, the response is built at the setup edge. In that
  // case the decode looks at the live inputs while in IDLE. In every other
  // state it looks only at the latched request, so input changes after
  // setup have no effect.
  always_comb begin
    w_addr  = r_paddr;
    w_write = r_pwrite;
    w_prot  = r_pprot;
    if (r_state == S_IDLE) begin
      w_addr  = i_paddr;
      w_write = i_pwrite;
      w_prot  = i_pprot;
    end
  end

  assign w_idx = w_addr[31:2];

  // Error decode: misaligned address, out-of-range index, or write to the ID word.
  always_comb begin
    w_err = 1'b0;
    if (w_addr[1:0] != 2'b00) begin
      w_err = 1'b1;
    end
    if (w_idx >= 30'(NUM_REGS)) begin
      w_err = 1'b1;
    end
    if (w_write && (w_idx == 30'd0)) begin
      w_err = 1'b1;
    end
`ifdef APB_SLV_PROT_CHECK_EN
    if (!w_prot[0] && (w_idx >= 30'(NUM_REGS / 2))) begin
      w_err = 1'b1;
    end
`endif
  end

  // Only pprot[0] takes part in the decode, and only when the check is built in.
  assign w_unused_prot = ^w_prot;

  // Read mux: index 0 returns the ID constant; storage slot 0 is never used.
  always_comb begin
    w_rdata = '0;
    if (w_idx == 30'd0) begin
      w_rdata = ID_VALUE;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_idx == 30'(i)) begin
        w_rdata = r_regs[i];
      end
    end
  end

  // Transfer FSM: registered response outputs and the register-bank commit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_psel && !i_penable) begin
            r_paddr  <= i_paddr;
            r_pwrite <= i_pwrite;
            r_pwdata <= i_pwdata;
            r_pstrb  <= i_pstrb;
            r_pprot  <= i_pprot;
            if (WAIT_CYCLES == 0) begin
              r_state   <= S_RESP;
              r_cnt     <= 4'd0;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= (!w_write && !w_err) ? w_rdata : 32'd0;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          if (!i_psel) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_state   <= S_RESP;
            r_cnt     <= 4'd0;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= (!w_write && !w_err) ? w_rdata : 32'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (r_pwrite && !w_err) begin
            for (int i = 1; i < NUM_REGS; i++) begin
              if (r_paddr[31:2] == 30'(i)) begin
                for (int b = 0; b < 4; b++) begin
                  if (r_pstrb[b]) begin
                    r_regs[i][8*b +: 8] <= r_pwdata[8*b +: 8];
                  end
                end
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign o_prdata  = r_prdata;
  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile. Instance 0 uses WAIT_CYCLES=1 and instance 1
// uses WAIT_CYCLES=3. Stimulus pushes each expected response into a
// per-instance queue. A negedge monitor pops the queue whenever pready is
// seen and compares data, error and latency. In every other cycle it checks
// that the outputs are quiet.

module tb_apb_slave_regfile;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          setup;
    int          lat;
    int          id;
  } exp_t;

  logic        clk;
  logic        rstn      [2];
  logic        psel      [2];
  logic        penable   [2];
  logic        pwrite    [2];
  logic [31:0] paddr     [2];
  logic [31:0] pwdata    [2];
  logic [3:0]  pstrb     [2];
  logic [2:0]  pprot     [2];
  logic [31:0] o_prdata  [2];
  logic        o_pready  [2];
  logic        o_pslverr [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vec = 0;

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rstn(rstn[0]), .i_psel(psel[0]), .i_penable(penable[0]),
    .i_pwrite(pwrite[0]), .i_paddr(paddr[0]), .i_pwdata(pwdata[0]),
    .i_pstrb(pstrb[0]), .i_pprot(pprot[0]), .o_prdata(o_prdata[0]),
    .o_pready(o_pready[0]), .o_pslverr(o_pslverr[0])
  );

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rstn(rstn[1]), .i_psel(psel[1]), .i_penable(penable[1]),
    .i_pwrite(pwrite[1]), .i_paddr(paddr[1]), .i_pwdata(pwdata[1]),
    .i_pstrb(pstrb[1]), .i_pprot(pprot[1]), .o_prdata(o_prdata[1]),
    .o_pready(o_pready[1]), .o_pslverr(o_pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon_one(input int d, input logic rdy, input logic [31:0] rd, input logic er);
    exp_t e;
    if (rdy === 1'b1) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready dut%0d cycle %0d prdata=%h pslverr=%b", d, cyc, rd, er);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        checks++;
        if (rd !== e.rdata) begin
          errors++;
          $display("FAIL prdata dut%0d vec%0d got %h want %h", d, e.id, rd, e.rdata);
        end
        checks++;
        if (er !== e.err) begin
          errors++;
          $display("FAIL pslverr dut%0d vec%0d got %b want %b", d, e.id, er, e.err);
        end
        checks++;
        if ((cyc - e.setup) != e.lat) begin
          errors++;
          $display("FAIL latency dut%0d vec%0d got %0d want %0d", d, e.id, cyc - e.setup, e.lat);
        end
      end
    end else begin
      checks++;
      if (rdy !== 1'b0 || rd !== 32'd0 || er !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs dut%0d cycle %0d pready=%b prdata=%h pslverr=%b want 0/0/0",
                 d, cyc, rdy, rd, er);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, o_pready[0], o_prdata[0], o_pslverr[0]);
    mon_one(1, o_pready[1], o_prdata[1], o_pslverr[1]);
  end

  // One complete APB transfer. Called #1 after a rising edge; returns the
  // same way, so back-to-back calls give a setup phase right after RESP.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input logic [31:0] exp_rd,
                      input logic exp_err, input bit glitch);
    exp_t e;
    int   n;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
    pprot[d]   = prot;
    @(posedge clk); #1;
    vec++;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.setup = cyc;
    e.lat   = (d == 0) ? 1 : 3;
    e.id    = vec;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    penable[d] = 1'b1;
    if (glitch) begin
      paddr[d]  = addr ^ 32'h4;
      pwdata[d] = ~wdata;
      pstrb[d]  = ~strb;
      pwrite[d] = ~wr;
      pprot[d]  = ~prot;
    end
    n = 0;
    while (o_pready[d] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_pready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout dut%0d vec%0d got no pready within 40 cycles", d, vec);
    end
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_lo_rd;
    logic        exp_prot_err;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_pready[d] !== 1'b0 || o_pslverr[d] !== 1'b0 || o_prdata[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %b/%b/%h want 0/0/0",
                 d, o_pready[d], o_pslverr[d], o_prdata[d]);
      end
    end

    // ---- instance 0, WAIT_CYCLES=1 ----
    xfer(0, 1, 32'h4,  32'hDEADBEEF, 4'hF, 3'b001, 32'h0,        0, 0);
    xfer(0, 0, 32'h4,  32'h0,        4'hF, 3'b001, 32'hDEADBEEF, 0, 0);
    xfer(0, 1, 32'h8,  32'h11223344, 4'hF, 3'b001, 32'h0,        0, 0);
    xfer(0, 1, 32'h8,  32'hAABBCCDD, 4'h5, 3'b001, 32'h0,        0, 0);
    xfer(0, 0, 32'h8,  32'h0,        4'hF, 3'b001, 32'h11BB33DD, 0, 0);
    xfer(0, 0, 32'h0,  32'h0,        4'hF, 3'b001, 32'hA5B00001, 0, 0);
    xfer(0, 1, 32'h0,  32'h12345678, 4'hF, 3'b001, 32'h0,        1, 0);
    xfer(0, 0, 32'h0,  32'h0,        4'hF, 3'b001, 32'hA5B00001, 0, 0);
    xfer(0, 0, 32'h40, 32'h0,        4'hF, 3'b001, 32'h0,        1, 0);
    xfer(0, 1, 32'h6,  32'hFFFFFFFF, 4'hF, 3'b001, 32'h0,        1, 0);
    xfer(0, 0, 32'h4,  32'h0,        4'h0, 3'b001, 32'hDEADBEEF, 0, 0);
    xfer(0, 1, 32'h8,  32'h0,        4'h0, 3'b001, 32'h0,        0, 0);
    xfer(0, 0, 32'h8,  32'h0,        4'h3, 3'b001, 32'h11BB33DD, 0, 0);
    xfer(0, 1, 32'h3C, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0,        0, 0);
    xfer(0, 0, 32'h3C, 32'h0,        4'hF, 3'b001, 32'hCAFEF00D, 0, 0);
    xfer(0, 0, 32'h3E, 32'h0,        4'hF, 3'b001, 32'h0,        1, 0);

    // Access phase without a setup phase: must be ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h4; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 0, 32'h4,  32'h0,        4'hF, 3'b001, 32'hDEADBEEF, 0, 0);

    // Unprivileged access to the upper half of the bank.
`ifdef APB_SLV_PROT_CHECK_EN
    exp_prot_err = 1'b1;
    exp_lo_rd    = 32'h0;
`else
    exp_prot_err = 1'b0;
    exp_lo_rd    = 32'h55AA55AA;
`endif
    xfer(0, 1, 32'h20, 32'h55AA55AA, 4'hF, 3'b000, 32'h0,        exp_prot_err, 0);
    xfer(0, 0, 32'h20, 32'h0,        4'hF, 3'b001, exp_lo_rd,    0, 0);
    xfer(0, 1, 32'h20, 32'h0F0F0F0F, 4'hF, 3'b001, 32'h0,        0, 0);
    xfer(0, 0, 32'h20, 32'h0,        4'hF, 3'b000,
         exp_prot_err ? 32'h0 : 32'h0F0F0F0F, exp_prot_err, 0);
    xfer(0, 0, 32'h20, 32'h0,        4'hF, 3'b001, 32'h0F0F0F0F, 0, 0);
    xfer(0, 1, 32'h1C, 32'h00000077, 4'hF, 3'b000, 32'h0,        0, 0);
    xfer(0, 0, 32'h1C, 32'h0,        4'hF, 3'b000, 32'h00000077, 0, 0);

    // ---- instance 1, WAIT_CYCLES=3 ----
    xfer(1, 1, 32'hC,  32'h12345678, 4'hF, 3'b001, 32'h0,        0, 0);
    xfer(1, 0, 32'hC,  32'h0,        4'hF, 3'b001, 32'h12345678, 0, 0);

    // Abort after one wait cycle: no pready, register 3 unchanged.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'hC; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF; pprot[1] = 3'b001;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    xfer(1, 0, 32'hC,  32'h0,        4'hF, 3'b001, 32'h12345678, 0, 0);

    // Inputs that change after the setup edge must be ignored.
    xfer(1, 1, 32'h10, 32'h0BADF00D, 4'hF, 3'b001, 32'h0,        0, 1);
    xfer(1, 0, 32'h10, 32'h0,        4'hF, 3'b001, 32'h0BADF00D, 0, 1);
    xfer(1, 0, 32'h14, 32'h0,        4'hF, 3'b001, 32'h0,        0, 0);

    // Reset during WAIT: the transfer is dropped and the bank is cleared.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h10; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF; pprot[1] = 3'b001;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    rstn[1] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_pready[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wait_pready got %b want 0", o_pready[1]);
    end
    rstn[1] = 1'b1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    xfer(1, 0, 32'hC,  32'h0,        4'hF, 3'b001, 32'h0,        0, 0);
    xfer(1, 0, 32'h10, 32'h0,        4'hF, 3'b001, 32'h0,        0, 0);
    xfer(1, 0, 32'h0,  32'h0,        4'hF, 3'b001, 32'hA5B00001, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL pending_responses got %0d/%0d want 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 The block SHALL provide parameter NUM_REGS, default 16, number of 32-bit registers (2..64).
REQ-002 The block SHALL provide parameter WAIT_CYCLES, default 1, access-phase cycles with pready low (0..15).
REQ-003 The block SHALL provide parameter ID_VALUE, default 32'hA5B0_0001, read-only contents of register 0.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 psel  input  1  completer select from bridge.
REQ-007 penable  input  1  access-phase indicator.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  32  byte address; word index = paddr[31:2].
REQ-010 pwdata  input  32  write data.
REQ-011 pstrb  input  4  write byte-lane strobes; pstrb[i] covers pwdata[8i+7:8i].
REQ-012 pprot  input  3  protection type; bit 0 = privileged.
REQ-013 prdata  output  32  read data, registered.
REQ-014 pready  output  1  transfer complete, registered.
REQ-015 pslverr  output  1  transfer error, registered, valid only while pready=1.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-017 In IDLE with psel=1 and penable=0 (setup phase), the block SHALL latch paddr, pwrite, pwdata, pstrb, pprot and go to RESP if WAIT_CYCLES=0, else go to WAIT with counter = WAIT_CYCLES.
REQ-018 In WAIT with psel=1, the counter SHALL decrement each cycle; the block SHALL go to RESP on the edge where counter = 1, so pready stays low for exactly WAIT_CYCLES access cycles.
REQ-019 In WAIT with psel=0 (aborted transfer), the block SHALL return to IDLE with no register update and no pready pulse.
REQ-020 pready SHALL be 1 only in RESP, for exactly one cycle; RESP SHALL always go to IDLE on the next edge.
REQ-021 Consecutive transfers SHALL be supported: a setup phase in the cycle after RESP SHALL be accepted from IDLE.
REQ-022 Error condition SHALL be any of: latched paddr[1:0] != 0; word index >= NUM_REGS; write to register 0.
REQ-023 In RESP, pslverr SHALL equal the error condition; otherwise pslverr SHALL be 0.
REQ-024 For a read in RESP without error, prdata SHALL equal the addressed register (ID_VALUE for index 0); prdata SHALL be 0 in all other cycles, on writes, and on errored reads.
REQ-025 A write without error SHALL commit on the edge leaving RESP and update only byte lanes with pstrb[i]=1; pstrb=4'b0000 SHALL leave the register unchanged with pslverr=0.
REQ-026 An errored write SHALL leave all registers unchanged.
REQ-027 pstrb SHALL be ignored on reads.
REQ-028 penable=1 sampled in IDLE (access without setup) SHALL be ignored and the block SHALL remain in IDLE.
REQ-029 Inputs SHALL be sampled only at the setup-phase edge; changes during WAIT or RESP SHALL have no effect.

Reset
REQ-030 With rstn=0 at a rising edge: state = IDLE, counter = 0, pready = 0, pslverr = 0, prdata = 0, registers 1..NUM_REGS-1 = 0.
REQ-031 Reset during WAIT or RESP SHALL abort the transfer with no register update; the first setup phase after release SHALL be accepted normally.

Configuration
REQ-032 With macro APB_SLV_PROT_CHECK_EN defined, any access with latched pprot[0]=0 to a word index >= NUM_REGS/2 SHALL be an error (pslverr=1, no write, prdata=0).
REQ-033 Without APB_SLV_PROT_CHECK_EN, pprot SHALL be ignored and SHALL NOT affect pslverr.

Verification
REQ-034 WAIT_CYCLES=1: write paddr=0x4, pwdata=0xDEADBEEF, pstrb=4'hF, then read 0x4 -> pready low 1 access cycle, high 1 cycle; prdata=0xDEADBEEF, pslverr=0.
REQ-035 Register 2 = 0x11223344, write 0x8 with pwdata=0xAABBCCDD, pstrb=4'b0101 -> read returns 0x11BB33DD.
REQ-036 Read 0x0 -> prdata=0xA5B00001, pslverr=0; write 0x0 -> pslverr=1; subsequent read still 0xA5B00001.
REQ-037 Read 0x40 (index 16, NUM_REGS=16) and write 0x6 (misaligned) -> pslverr=1 on each; prdata=0; no register changed.
REQ-038 WAIT_CYCLES=3, write 0xC then drop psel after 1 WAIT cycle -> no pready pulse, register 3 unchanged; rstn=0 during a later WAIT -> registers cleared, pready=0.
REQ-039 APB_SLV_PROT_CHECK_EN defined: write 0x20 (index 8) with pprot=3'b000 -> pslverr=1, no write; same write with pprot=3'b001 -> pslverr=0, written.
